// File: rtl/vacc_packetizer.sv
// vacc_packetizer: captures accumulator spectra into a ping-pong BRAM pair
// and replays each one as a single AXI4-Stream packet.
// Optional header beat carrying a 48-bit frame number: define VACC_PKT_HEADER_EN.
module vacc_packetizer #(
    parameter int VECTOR_WIDTH = 11,
    parameter int DATA_WIDTH   = 128,
    parameter int AXIS_WIDTH   = 64,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    we,
    input  logic [VECTOR_WIDTH-1:0] addr,
    output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [COUNT_WIDTH-1:0]  frames_dropped,
    output logic [COUNT_WIDTH-1:0]  frames_aborted
);
    localparam int N       = 1 << VECTOR_WIDTH;
    localparam int B       = DATA_WIDTH / AXIS_WIDTH;
    localparam int SLICE_W = (B > 1) ? $clog2(B) : 1;
    localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR  = VECTOR_WIDTH'(N - 1);
    localparam logic [SLICE_W-1:0]      LAST_SLICE = SLICE_W'(B - 1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
`ifdef VACC_PKT_HEADER_EN
    localparam logic [1:0] R_HDR  = 2'd1;
`endif
    localparam logic [1:0] R_DATA = 2'd2;

    // Both banks live in one array, bank select is the top address bit.
    logic [DATA_WIDTH-1:0] mem [0:2*N-1];
    logic [DATA_WIDTH-1:0] rd_word_reg;

    logic [1:0]              w_state_reg, w_state_next;
    logic [VECTOR_WIDTH-1:0] exp_addr_reg, exp_addr_next;
    logic                    wr_bank_reg, rd_bank_reg, iss_bank_reg;
    logic [1:0]              bank_full_reg, bank_full_next;

    logic acc, addr_is_first, addr_is_last, bank_free, rd_done;
    logic mem_we, frame_start, fill_done, drop_inc, abort_inc;

    logic [1:0]              rd_state_reg;
    logic [VECTOR_WIDTH-1:0] word_cnt_reg;
    logic [SLICE_W-1:0]      slice_cnt_reg;
    logic                    pipe_en, issue_valid, issue_last, issue_hdr;
    logic                    b_valid_reg, b_last_reg;
    logic [SLICE_W-1:0]      b_slice_reg;
    logic [AXIS_WIDTH-1:0]   word_slices [0:B-1];
    logic [AXIS_WIDTH-1:0]   beat_data;

    assign acc           = ce && we;
    assign addr_is_first = (addr == '0);
    assign addr_is_last  = (addr == LAST_ADDR);
    assign rd_done       = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    // A bank being released by the reader this very cycle counts as free.
    assign bank_free     = !bank_full_reg[wr_bank_reg] || (rd_done && (rd_bank_reg == wr_bank_reg));

    // Write-side sequencing: track expected address, decide store / drop / abort.
    always_comb begin
        w_state_next  = w_state_reg;
        exp_addr_next = exp_addr_reg;
        mem_we        = 1'b0;
        frame_start   = 1'b0;
        fill_done     = 1'b0;
        drop_inc      = 1'b0;
        abort_inc     = 1'b0;
        if (acc) begin
            if (w_state_reg == W_IDLE) begin
                frame_start = addr_is_first;
            end else if (addr == exp_addr_reg) begin
                mem_we = (w_state_reg == W_FILL);
                if (addr_is_last) begin
                    fill_done    = (w_state_reg == W_FILL);
                    w_state_next = W_IDLE;
                end else begin
                    exp_addr_next = exp_addr_reg + VECTOR_WIDTH'(1);
                end
            end else begin
                abort_inc    = 1'b1;
                frame_start  = addr_is_first;
                w_state_next = W_IDLE;
            end
            if (frame_start) begin
                exp_addr_next = VECTOR_WIDTH'(1);
                if (bank_free) begin
                    mem_we       = 1'b1;
                    fill_done    = addr_is_last;
                    w_state_next = addr_is_last ? W_IDLE : W_FILL;
                end else begin
                    drop_inc     = 1'b1;
                    w_state_next = addr_is_last ? W_IDLE : W_DROP;
                end
            end
        end
    end

    // Fill completion and read completion always target opposite banks.
    always_comb begin
        bank_full_next = bank_full_reg;
        if (rd_done)
            bank_full_next[rd_bank_reg] = 1'b0;
        if (fill_done)
            bank_full_next[wr_bank_reg] = 1'b1;
    end

    // Write FSM, bank flags, bank pointers and saturating status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg    <= W_IDLE;
            exp_addr_reg   <= '0;
            bank_full_reg  <= '0;
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b0;
            frames_dropped <= '0;
            frames_aborted <= '0;
        end else begin
            w_state_reg   <= w_state_next;
            exp_addr_reg  <= exp_addr_next;
            bank_full_reg <= bank_full_next;
            if (fill_done)
                wr_bank_reg <= ~wr_bank_reg;
            if (rd_done)
                rd_bank_reg <= ~rd_bank_reg;
            if (drop_inc && (frames_dropped != '1))
                frames_dropped <= frames_dropped + COUNT_WIDTH'(1);
            if (abort_inc && (frames_aborted != '1))
                frames_aborted <= frames_aborted + COUNT_WIDTH'(1);
        end
    end

    // Block RAM: write port from the capture side, registered read stalled with the output.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[{wr_bank_reg, addr}] <= data_in;
        if (pipe_en)
            rd_word_reg <= mem[{iss_bank_reg, word_cnt_reg}];
    end

`ifdef VACC_PKT_HEADER_EN
    logic [47:0]      seq_reg;
    logic [1:0][47:0] seq_bank_reg;
    logic             b_hdr_reg;
    logic [47:0]      b_seq_reg;

    // Frame numbering: every start bumps seq, accepted starts latch it per bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_reg      <= '0;
            seq_bank_reg <= '0;
        end else if (frame_start) begin
            seq_reg <= seq_reg + 48'd1;
            if (bank_free)
                seq_bank_reg[wr_bank_reg] <= seq_reg;
        end
    end

    // Header travels alongside the BRAM read stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_hdr_reg <= 1'b0;
            b_seq_reg <= '0;
        end else if (pipe_en) begin
            b_hdr_reg <= issue_hdr;
            b_seq_reg <= seq_bank_reg[iss_bank_reg];
        end
    end
    assign issue_hdr = (rd_state_reg == R_HDR);
`else
    assign issue_hdr = 1'b0;
`endif

    // Whole read pipeline advances together whenever the output slot can move.
    assign pipe_en     = !m_axis_tvalid || m_axis_tready;
    assign issue_valid = (rd_state_reg != R_IDLE);
    assign issue_last  = (rd_state_reg == R_DATA) && (word_cnt_reg == LAST_ADDR) &&
                         (slice_cnt_reg == LAST_SLICE);

    // Read FSM: issues one beat per enabled cycle; issue bank runs ahead of rd_bank by one packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_reg  <= R_IDLE;
            word_cnt_reg  <= '0;
            slice_cnt_reg <= '0;
            iss_bank_reg  <= 1'b0;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    word_cnt_reg  <= '0;
                    slice_cnt_reg <= '0;
                    if (bank_full_reg[iss_bank_reg]) begin
`ifdef VACC_PKT_HEADER_EN
                        rd_state_reg <= R_HDR;
`else
                        rd_state_reg <= R_DATA;
`endif
                    end
                end
                R_DATA: begin
                    if (pipe_en) begin
                        if (issue_last) begin
                            rd_state_reg <= R_IDLE;
                            iss_bank_reg <= ~iss_bank_reg;
                        end else if (slice_cnt_reg == LAST_SLICE) begin
                            slice_cnt_reg <= '0;
                            word_cnt_reg  <= word_cnt_reg + VECTOR_WIDTH'(1);
                        end else begin
                            slice_cnt_reg <= slice_cnt_reg + SLICE_W'(1);
                        end
                    end
                end
                default: begin
                    if (pipe_en)
                        rd_state_reg <= R_DATA;
                end
            endcase
        end
    end

    // Beat attributes delayed to line up with the registered BRAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_reg <= 1'b0;
            b_last_reg  <= 1'b0;
            b_slice_reg <= '0;
        end else if (pipe_en) begin
            b_valid_reg <= issue_valid;
            b_last_reg  <= issue_last;
            b_slice_reg <= slice_cnt_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < B; gi++) begin : g_slice
            assign word_slices[gi] = rd_word_reg[gi*AXIS_WIDTH +: AXIS_WIDTH];
        end
    endgenerate

    // Select the outgoing beat: least-significant slice first, or the header.
    always_comb begin
        beat_data = word_slices[b_slice_reg];
`ifdef VACC_PKT_HEADER_EN
        if (b_hdr_reg)
            beat_data = AXIS_WIDTH'({16'h5A5A, b_seq_reg});
`endif
    end

    // Output register: holds its beat while the sink stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (pipe_en) begin
            m_axis_tvalid <= b_valid_reg;
            m_axis_tlast  <= b_valid_reg && b_last_reg;
            m_axis_tdata  <= beat_data;
        end
    end
endmodule

// File: tb/tb_vacc_packetizer.sv
// Directed bench for vacc_packetizer with N=8 words of 128 bits, 64-bit beats.
// Follows VACC_PKT_HEADER_EN to expect the optional header beat.
module tb_vacc_packetizer;
    localparam int VW = 3;
    localparam int DW = 128;
    localparam int AW = 64;
    localparam int CW = 32;
`ifdef VACC_PKT_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif
    localparam int PKT = 16 + HB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          we = 1'b0;
    logic [VW-1:0] addr = '0;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [CW-1:0] frames_dropped;
    logic [CW-1:0] frames_aborted;

    int checks = 0;
    int errors = 0;
    int stab_viol = 0;
    logic [64:0] beat_q[$];
    logic [64:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always #5 clk = ~clk;

    vacc_packetizer #(
        .VECTOR_WIDTH(VW), .DATA_WIDTH(DW), .AXIS_WIDTH(AW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .data_in(data_in), .we(we), .addr(addr),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frames_dropped(frames_dropped), .frames_aborted(frames_aborted)
    );

    // Sink monitor: records handshaken beats, flags any change while stalled.
    always @(negedge clk) begin
        if (!rst && prev_stall &&
            (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
            stab_viol++;
        if (!rst && m_axis_tvalid && m_axis_tready)
            beat_q.push_back({m_axis_tlast, m_axis_tdata});
        prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic c, input logic w, input int a, input logic [DW-1:0] d);
        ce = c;
        we = w;
        addr = VW'(a);
        data_in = d;
        tick();
    endtask

    function automatic logic [DW-1:0] word(input logic [63:0] base, input int k);
        return {base + 64'hB0 + 64'(k), base + 64'hA0 + 64'(k)};
    endfunction

    task automatic write_frame(input logic [63:0] base);
        for (int k = 0; k < 8; k++)
            put(1'b1, 1'b1, k, word(base, k));
        we = 1'b0;
        ce = 1'b0;
    endtask

    task automatic idle(input int n);
        we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic push_expected(input logic [63:0] base, input logic [47:0] seq);
        if (HB != 0)
            exp_q.push_back({1'b0, 16'h5A5A, seq});
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({1'b0, base + 64'hA0 + 64'(k)});
            exp_q.push_back({k == 7, base + 64'hB0 + 64'(k)});
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while (beat_q.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_axis_tready = 1'b1;
        idle(3);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if (frames_dropped !== '0) begin errors++; $display("FAIL reset_dropped got %0d want 0", frames_dropped); end
        checks++; if (frames_aborted !== '0) begin errors++; $display("FAIL reset_aborted got %0d want 0", frames_aborted); end
        rst = 1'b0;
        idle(2);
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        logic [64:0] got;
        beat_q.delete(); exp_q.delete();
        m_axis_tready = 1'b1;
        write_frame(64'h0);
        push_expected(64'h0, 48'd0);
        wait_beats(PKT, 200);
        idle(20);
        $display("basic: packet of %0d beats", beat_q.size());
        checks++; if (beat_q.size() != PKT) begin errors++; $display("FAIL basic_len got %0d want %0d", beat_q.size(), PKT); end
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] got;
        int c = 0;
        beat_q.delete(); exp_q.delete();
        stab_viol = 0;
        m_axis_tready = 1'b0;
        write_frame(64'h40);
        push_expected(64'h40, 48'd1);
        while (beat_q.size() < PKT && c < 400) begin
            m_axis_tready = ($urandom_range(0, 1) == 1);
            tick();
            c++;
        end
        m_axis_tready = 1'b1;
        idle(20);
        $display("backpressure: packet of %0d beats over %0d cycles", beat_q.size(), c);
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab_viol); end
        checks++; if (beat_q.size() != PKT) begin errors++; $display("FAIL bp_len got %0d want %0d", beat_q.size(), PKT); end
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_drop();
        logic [64:0] got;
        beat_q.delete(); exp_q.delete();
        m_axis_tready = 1'b0;
        write_frame(64'h100);
        write_frame(64'h200);
        write_frame(64'h300);
        idle(5);
        checks++; if (frames_dropped !== 32'd1) begin errors++; $display("FAIL drop_count got %0d want 1", frames_dropped); end
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL drop_hold_valid got %b want 1", m_axis_tvalid); end
        checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL drop_stalled got %0d beats want 0", beat_q.size()); end
        push_expected(64'h100, 48'd2);
        push_expected(64'h200, 48'd3);
        m_axis_tready = 1'b1;
        wait_beats(2 * PKT, 300);
        idle(30);
        $display("drop: %0d beats for two packets", beat_q.size());
        checks++; if (beat_q.size() != 2 * PKT) begin errors++; $display("FAIL drop_len got %0d want %0d", beat_q.size(), 2 * PKT); end
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL drop_beat%0d got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        logic [64:0] got;
        beat_q.delete(); exp_q.delete();
        m_axis_tready = 1'b1;
        put(1'b1, 1'b1, 0, word(64'h400, 0));
        put(1'b1, 1'b1, 1, word(64'h400, 1));
        put(1'b1, 1'b1, 2, word(64'h400, 2));
        put(1'b1, 1'b1, 5, word(64'h400, 5));
        put(1'b1, 1'b1, 6, word(64'h400, 6));
        put(1'b1, 1'b1, 7, word(64'h400, 7));
        idle(20);
        checks++; if (frames_aborted !== 32'd1) begin errors++; $display("FAIL abort_count1 got %0d want 1", frames_aborted); end
        checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL abort_nopkt got %0d beats want 0", beat_q.size()); end
        put(1'b1, 1'b1, 0, word(64'h450, 0));
        put(1'b1, 1'b1, 1, word(64'h450, 1));
        write_frame(64'h500);
        push_expected(64'h500, 48'd7);
        wait_beats(PKT, 200);
        idle(20);
        $display("abort: restarted frame gave %0d beats", beat_q.size());
        checks++; if (frames_aborted !== 32'd2) begin errors++; $display("FAIL abort_count2 got %0d want 2", frames_aborted); end
        checks++; if (frames_dropped !== 32'd1) begin errors++; $display("FAIL abort_dropped got %0d want 1", frames_dropped); end
        checks++; if (beat_q.size() != PKT) begin errors++; $display("FAIL abort_len got %0d want %0d", beat_q.size(), PKT); end
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL abort_beat%0d got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_ce_gaps();
        logic [64:0] got;
        beat_q.delete(); exp_q.delete();
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            put(1'b1, 1'b1, k, word(64'h700, k));
            put(1'b0, 1'b1, (k % 2 == 0) ? 3 : 0, {2{64'hDEAD_BEEF_0000_0000 + 64'(k)}});
            if (k == 4)
                put(1'b1, 1'b0, 6, '1);
        end
        we = 1'b0;
        push_expected(64'h700, 48'd8);
        wait_beats(PKT, 200);
        idle(20);
        $display("ce_gaps: packet of %0d beats", beat_q.size());
        checks++; if (frames_aborted !== 32'd2) begin errors++; $display("FAIL ce_aborted got %0d want 2", frames_aborted); end
        checks++; if (beat_q.size() != PKT) begin errors++; $display("FAIL ce_len got %0d want %0d", beat_q.size(), PKT); end
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL ce_beat%0d got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] got;
        beat_q.delete(); exp_q.delete();
        m_axis_tready = 1'b1;
        write_frame(64'h800);
        wait_beats(5, 200);
        rst = 1'b1;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (frames_dropped !== '0) begin errors++; $display("FAIL rstmid_dropped got %0d want 0", frames_dropped); end
        checks++; if (frames_aborted !== '0) begin errors++; $display("FAIL rstmid_aborted got %0d want 0", frames_aborted); end
        rst = 1'b0;
        idle(2);
        beat_q.delete();
        idle(40);
        checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL rstmid_replay got %0d beats want 0", beat_q.size()); end
        write_frame(64'h900);
        push_expected(64'h900, 48'd0);
        wait_beats(PKT, 200);
        idle(20);
        $display("reset_mid: post-reset packet of %0d beats", beat_q.size());
        checks++; if (beat_q.size() != PKT) begin errors++; $display("FAIL rstmid_len got %0d want %0d", beat_q.size(), PKT); end
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_abort();
        test_ce_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
